cache_refill_unit: RTL

- Upstream write-side stage of the cache data BRAM wrapper.
- Accepts a line-miss request and issues a burst read on the memory port.
- Collects DATA_WIDTH beats into a LINE_WIDTH line buffer, then writes the whole line into the BRAM write port in a single cycle.
- Signals completion to the cache controller so it can replay the read through the BRAM read port, which forwards the freshly written line.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/refill_line_buffer.sv | 41 ++++
 rtl/cache_refill_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types, constants and address helper for the cache line refill path.
// WORDS and CNT_W follow from the default line and beat widths held here.
package cache_pkg;

    localparam int unsigned DEF_LINE_WIDTH = 256;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 128;
    localparam int unsigned DEF_ADDR_WIDTH = 32;

    localparam int unsigned WORDS    = DEF_LINE_WIDTH / DEF_DATA_WIDTH;
    localparam int unsigned CNT_W    = $clog2(WORDS);
    localparam int unsigned OFFSET_W = $clog2(DEF_LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        WRITE
    } refill_state_e;

    // Drop the byte offset within a line so bursts always start on a line boundary.
    function automatic logic [DEF_ADDR_WIDTH-1:0] line_align(input logic [DEF_ADDR_WIDTH-1:0] addr);
        line_align = {addr[DEF_ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// Line assembly buffer: one register per beat plus a mask of which words arrived.
// Word 0 occupies the least significant bits of the assembled line.
module refill_line_buffer
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        wr_i,
    input  logic [CNT_W-1:0]            idx_i,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    output logic [WORDS*DATA_WIDTH-1:0] line_o,
    output logic [WORDS-1:0]            mask_o
);

    logic [WORDS-1:0][DATA_WIDTH-1:0] words_q;
    logic [WORDS-1:0]                 mask_q;

    // Data storage carries no reset; the mask alone says which words are valid.
    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            words_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
        end else if (clr_i) begin
            mask_q <= '0;
        end else if (wr_i) begin
            mask_q[idx_i] <= 1'b1;
        end
    end

    assign line_o = words_q;
    assign mask_o = mask_q;

endmodule

// File: rtl/cache_refill_unit.sv
// Refill engine: takes a line miss, bursts the line in from memory, and writes
// the assembled line into the cache BRAM in one cycle with a completion pulse.
module cache_refill_unit
    import cache_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [IDX_W-1:0]      req_index_i,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [CNT_W:0]        mem_req_len_o,
    input  logic                  mem_rvalid_i,
    output logic                  mem_rready_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_rlast_i,

    output logic                  bram_wen_o,
    output logic [WORDS-1:0]      bram_wmask_o,
    output logic [IDX_W-1:0]      bram_waddr_o,
    output logic [LINE_WIDTH-1:0] bram_wline_o,

    output logic                  fill_done_o,
    output logic                  fill_err_o,
    output logic [IDX_W-1:0]      fill_index_o
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W:0]   BURST_LEN = (CNT_W + 1)'(WORDS);

    refill_state_e         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  err_q, err_d;

    logic                  buf_clr;
    logic                  buf_wr;
    logic [LINE_WIDTH-1:0] buf_line;
    logic [WORDS-1:0]      buf_mask;
    logic                  last_beat;

    refill_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buffer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (buf_clr),
        .wr_i    (buf_wr),
        .idx_i   (cnt_q),
        .wdata_i (mem_rdata_i),
        .line_o  (buf_line),
        .mask_o  (buf_mask)
    );

    assign last_beat     = (cnt_q == LAST_IDX);
    assign mem_req_len_o = BURST_LEN;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            index_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            index_q <= index_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        index_d         = index_q;
        err_d           = err_q;
        buf_clr         = 1'b0;
        buf_wr          = 1'b0;
        req_ready_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        mem_rready_o    = 1'b0;
        bram_wen_o      = 1'b0;
        bram_wmask_o    = '0;
        bram_waddr_o    = '0;
        bram_wline_o    = '0;
        fill_done_o     = 1'b0;
        fill_err_o      = 1'b0;
        fill_index_o    = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = line_align(req_addr_i);
                    index_d = req_index_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    buf_clr = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = addr_q;
                if (mem_req_ready_i) begin
                    state_d = RECV;
                end
            end
            // The counter stops on the terminating beat so it can never wrap.
            RECV: begin
                mem_rready_o = 1'b1;
                if (mem_rvalid_i) begin
                    buf_wr = 1'b1;
                    if (mem_rlast_i || last_beat) begin
                        err_d   = mem_rlast_i ^ last_beat;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                bram_wen_o   = 1'b1;
                bram_wmask_o = buf_mask;
                bram_waddr_o = index_q;
                bram_wline_o = buf_line;
                fill_done_o  = 1'b1;
                fill_err_o   = err_q;
                fill_index_o = index_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
